// File: rtl/hazard_sequencer_if.sv
// Decode-side hazard inputs and stall/flush outputs shared between
// the pipeline control logic and the hazard sequencer.
interface hazard_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs_D;
    logic [4:0]       Rt_D;
    logic             Uses_Rt_D;
    logic             Branch_D;
    logic             Branch_Taken_D;
    logic             Mem_Read_E;
    logic             Reg_Write_E;
    logic [4:0]       Write_Reg_E;
    logic             Mem_To_Reg_M;
    logic [4:0]       Write_Reg_M;
    logic             Mem_Access_M;
    logic             Mem_Ready;

    logic             Stall_F;
    logic             Stall_D;
    logic             Stall_E;
    logic             Stall_M;
    logic             Flush_D;
    logic             Flush_E;
    logic             Mem_Timeout;
    logic [1:0]       State;
    logic [CNT_W-1:0] Stall_Cycles;

    modport master (
        output Rs_D, Rt_D, Uses_Rt_D, Branch_D, Branch_Taken_D,
               Mem_Read_E, Reg_Write_E, Write_Reg_E,
               Mem_To_Reg_M, Write_Reg_M, Mem_Access_M, Mem_Ready,
        input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E,
               Mem_Timeout, State, Stall_Cycles
    );

    modport slave (
        input  Rs_D, Rt_D, Uses_Rt_D, Branch_D, Branch_Taken_D,
               Mem_Read_E, Reg_Write_E, Write_Reg_E,
               Mem_To_Reg_M, Write_Reg_M, Mem_Access_M, Mem_Ready,
        output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E,
               Mem_Timeout, State, Stall_Cycles
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use and branch
// operand interlocks, taken-branch squash, data-memory wait with watchdog.
module hazard_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int WAIT_W      = 8,
    parameter int CNT_W       = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    hazard_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10
    } state_t;

    localparam int                WAIT_EXT  = WAIT_W + 1;
    localparam logic [WAIT_W:0]   TIMEOUT_V = WAIT_EXT'(MEM_TIMEOUT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [WAIT_W:0]   w_wait_inc;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_lu;
    logic w_bh;
    logic w_mw;
    logic w_stall_f;
    logic w_stall_d;
    logic w_stall_e;
    logic w_stall_m;
    logic w_flush_d;
    logic w_flush_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Register 0 is hardwired, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    assign w_lu = bus.Mem_Read_E &&
                  (reg_match(bus.Write_Reg_E, bus.Rs_D) ||
                   (bus.Uses_Rt_D && reg_match(bus.Write_Reg_E, bus.Rt_D)));

    assign w_bh = bus.Branch_D &&
                  ((bus.Reg_Write_E &&
                    (reg_match(bus.Write_Reg_E, bus.Rs_D) || reg_match(bus.Write_Reg_E, bus.Rt_D))) ||
                   (bus.Mem_To_Reg_M &&
                    (reg_match(bus.Write_Reg_M, bus.Rs_D) || reg_match(bus.Write_Reg_M, bus.Rt_D))));

    assign w_mw       = bus.Mem_Access_M && !bus.Mem_Ready;
    assign w_wait_inc = {1'b0, r_wait} + WAIT_EXT'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_stall_f   = 1'b0;
        w_stall_d   = 1'b0;
        w_stall_e   = 1'b0;
        w_stall_m   = 1'b0;
        w_flush_d   = 1'b0;
        w_flush_e   = 1'b0;

        unique case (r_state)
            ST_RUN: begin
                if (w_mw) begin
                    {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = WAIT_W'(1);
                end else if (w_lu || w_bh) begin
                    w_stall_f = 1'b1;
                    w_stall_d = 1'b1;
                    w_flush_e = 1'b1;
                end else begin
                    w_flush_d = bus.Branch_D && bus.Branch_Taken_D;
                end
            end
            ST_MEM_WAIT: begin
                // A completing access releases the freeze in the same cycle,
                // so pending interlocks and branch squashes apply immediately.
                if (bus.Mem_Ready) begin
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                    if (w_lu || w_bh) begin
                        w_stall_f = 1'b1;
                        w_stall_d = 1'b1;
                        w_flush_e = 1'b1;
                    end else begin
                        w_flush_d = bus.Branch_D && bus.Branch_Taken_D;
                    end
                end else begin
                    {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
                    w_wait_nxt = w_wait_inc[WAIT_W-1:0];
                    if (w_wait_inc >= TIMEOUT_V) begin
                        w_state_nxt = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        if (Rst) begin
            w_stall_f = 1'b0;
            w_stall_d = 1'b0;
            w_stall_e = 1'b0;
            w_stall_m = 1'b0;
            w_flush_d = 1'b0;
            w_flush_e = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= ST_RUN;
            r_wait      <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            if (w_state_nxt == ST_HALT) begin
                r_timeout <= 1'b1;
            end
            if (w_stall_f) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    assign bus.Stall_F      = w_stall_f;
    assign bus.Stall_D      = w_stall_d;
    assign bus.Stall_E      = w_stall_e;
    assign bus.Stall_M      = w_stall_m;
    assign bus.Flush_D      = w_flush_d;
    assign bus.Flush_E      = w_flush_e;
    assign bus.Mem_Timeout  = r_timeout;
    assign bus.State        = r_state;
    assign bus.Stall_Cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed and randomized checks of hazard_sequencer against a cycle-level
// reference model derived from the pipeline hazard rules.
module tb_hazard_sequencer;
    localparam int MEM_TIMEOUT = 4;
    localparam int WAIT_W      = 8;
    localparam int CNT_W       = 6;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model: 0 running, 1 waiting on memory, 2 halted
    int         m_mode;
    int         m_wait;
    int         m_cnt;
    bit         m_to;
    logic [5:0] e_ctl;

    hazard_sequencer_if #(.CNT_W(CNT_W)) bus ();

    hazard_sequencer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .WAIT_W     (WAIT_W),
        .CNT_W      (CNT_W)
    ) dut (
        .Clk(clk),
        .Rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] ctl();
        return {bus.Stall_F, bus.Stall_D, bus.Stall_E, bus.Stall_M, bus.Flush_D, bus.Flush_E};
    endfunction

    function automatic bit dep(input logic [4:0] d, input logic [4:0] s);
        return (d != 5'd0) && (d == s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mode = 0;
        m_wait = 0;
        m_cnt  = 0;
        m_to   = 1'b0;
    endtask

    task automatic clr();
        bus.Rs_D = '0; bus.Rt_D = '0; bus.Uses_Rt_D = 0;
        bus.Branch_D = 0; bus.Branch_Taken_D = 0;
        bus.Mem_Read_E = 0; bus.Reg_Write_E = 0; bus.Write_Reg_E = '0;
        bus.Mem_To_Reg_M = 0; bus.Write_Reg_M = '0;
        bus.Mem_Access_M = 0; bus.Mem_Ready = 0;
    endtask

    // Settle combinational outputs, predict them, compare everything visible.
    task automatic settle(input string tag);
        bit lu, bh, mw, frozen;
        #1;
        if (rst) m_reset();
        lu = bus.Mem_Read_E && (dep(bus.Write_Reg_E, bus.Rs_D) ||
                                (bus.Uses_Rt_D && dep(bus.Write_Reg_E, bus.Rt_D)));
        bh = bus.Branch_D &&
             ((bus.Reg_Write_E && (dep(bus.Write_Reg_E, bus.Rs_D) || dep(bus.Write_Reg_E, bus.Rt_D))) ||
              (bus.Mem_To_Reg_M && (dep(bus.Write_Reg_M, bus.Rs_D) || dep(bus.Write_Reg_M, bus.Rt_D))));
        mw = bus.Mem_Access_M && !bus.Mem_Ready;
        frozen = (m_mode == 2) || (m_mode == 1 && !bus.Mem_Ready) || (m_mode == 0 && mw);
        e_ctl = 6'b000000;
        if (!rst) begin
            if (frozen)                                e_ctl = 6'b111100;
            else if (lu || bh)                         e_ctl = 6'b110001;
            else if (bus.Branch_D && bus.Branch_Taken_D) e_ctl = 6'b000010;
        end
        chk({tag, ":ctl"},   ctl(),            e_ctl);
        chk({tag, ":state"}, bus.State,        m_mode);
        chk({tag, ":tmo"},   bus.Mem_Timeout,  m_to);
        chk({tag, ":cnt"},   bus.Stall_Cycles, m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            if (e_ctl[5] && m_cnt < CNT_MAX) m_cnt++;
            if (m_mode == 0) begin
                if (bus.Mem_Access_M && !bus.Mem_Ready) begin
                    m_mode = 1;
                    m_wait = 1;
                end
            end else if (m_mode == 1) begin
                if (bus.Mem_Ready) begin
                    m_mode = 0;
                    m_wait = 0;
                end else begin
                    m_wait++;
                    if (m_wait >= MEM_TIMEOUT) begin
                        m_mode = 2;
                        m_to   = 1'b1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic step(input string tag);
        settle(tag);
        tick();
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        step("rst_pulse");
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        m_reset();

        settle("reset");
        chk("reset_ctl",   ctl(),            6'b000000);
        chk("reset_state", bus.State,        2'b00);
        chk("reset_cnt",   bus.Stall_Cycles, 0);
        tick();
        step("reset2");
        rst = 1'b0;
        step("idle");

        // LW r2 in EX, ADD using r2 in decode
        bus.Mem_Read_E = 1; bus.Reg_Write_E = 1; bus.Write_Reg_E = 5'd2; bus.Rs_D = 5'd2;
        settle("lu");
        chk("lu_ctl", ctl(), 6'b110001);
        tick();
        clr(); bus.Rs_D = 5'd2; bus.Mem_To_Reg_M = 1; bus.Write_Reg_M = 5'd2;
        bus.Mem_Access_M = 1; bus.Mem_Ready = 1;
        settle("lu_after");
        chk("lu_after_ctl", ctl(), 6'b000000);
        tick();

        // load into r0 never interlocks
        clr(); bus.Mem_Read_E = 1; bus.Reg_Write_E = 1; bus.Write_Reg_E = 5'd0; bus.Rs_D = 5'd0;
        settle("lu_r0");
        chk("lu_r0_ctl", ctl(), 6'b000000);
        tick();

        // Rt dependency only counts when the decode instruction reads Rt
        clr(); bus.Mem_Read_E = 1; bus.Write_Reg_E = 5'd9; bus.Rs_D = 5'd1; bus.Rt_D = 5'd9;
        step("lu_rt_unused");
        bus.Uses_Rt_D = 1;
        step("lu_rt_used");

        // taken BEQ without hazard
        clr(); bus.Branch_D = 1; bus.Branch_Taken_D = 1; bus.Rs_D = 5'd3; bus.Rt_D = 5'd4;
        settle("beq");
        chk("beq_ctl", ctl(), 6'b000010);
        tick();

        // BEQ on r5 while ADD r5 sits in EX
        clr(); bus.Branch_D = 1; bus.Branch_Taken_D = 1; bus.Rs_D = 5'd5; bus.Rt_D = 5'd6;
        bus.Reg_Write_E = 1; bus.Write_Reg_E = 5'd5;
        settle("bh");
        chk("bh_ctl", ctl(), 6'b110001);
        tick();
        bus.Reg_Write_E = 0; bus.Write_Reg_E = 5'd0;
        settle("bh_after");
        chk("bh_after_ctl", ctl(), 6'b000010);
        tick();

        // BEQ operand still loading in MEM
        clr(); bus.Branch_D = 1; bus.Rs_D = 5'd1; bus.Rt_D = 5'd7;
        bus.Mem_To_Reg_M = 1; bus.Write_Reg_M = 5'd7; bus.Mem_Access_M = 1; bus.Mem_Ready = 1;
        step("bh_mem");

        // three cycles of memory wait
        clr(); rst_pulse();
        bus.Mem_Access_M = 1; bus.Mem_Ready = 0;
        settle("mw0");
        chk("mw0_ctl", ctl(), 6'b111100);
        tick();
        step("mw1");
        settle("mw2");
        chk("mw2_state", bus.State, 2'b01);
        tick();
        bus.Mem_Ready = 1;
        settle("mw3");
        chk("mw3_ctl",   ctl(),     6'b000000);
        chk("mw3_state", bus.State, 2'b01);
        tick();
        clr();
        settle("mw_done");
        chk("mw_done_state", bus.State,        2'b00);
        chk("mw_done_cnt",   bus.Stall_Cycles, 3);
        tick();

        // memory wait and load-use together
        bus.Mem_Access_M = 1; bus.Mem_Ready = 0;
        bus.Mem_Read_E = 1; bus.Write_Reg_E = 5'd7; bus.Rs_D = 5'd7;
        settle("mwlu0");
        chk("mwlu0_ctl", ctl(), 6'b111100);
        tick();
        step("mwlu1");
        bus.Mem_Ready = 1;
        settle("mwlu_rel");
        chk("mwlu_rel_ctl", ctl(), 6'b110001);
        tick();
        clr();
        step("mwlu_clear");

        // watchdog expiry, saturation, asynchronous reset out of HALT
        rst_pulse();
        bus.Mem_Access_M = 1; bus.Mem_Ready = 0;
        for (int i = 0; i < 4; i++) step("to_wait");
        settle("halt");
        chk("halt_state", bus.State,       2'b10);
        chk("halt_tmo",   bus.Mem_Timeout, 1'b1);
        chk("halt_ctl",   ctl(),           6'b111100);
        tick();
        for (int i = 0; i < 70; i++) begin
            bus.Mem_Ready = 1'($urandom_range(0, 1));
            step("halt_hold");
        end
        settle("sat");
        chk("sat_cnt", bus.Stall_Cycles, CNT_MAX);
        #2;
        rst = 1'b1;
        settle("async_rst");
        chk("async_state", bus.State,        2'b00);
        chk("async_tmo",   bus.Mem_Timeout,  1'b0);
        chk("async_cnt",   bus.Stall_Cycles, 0);
        chk("async_ctl",   ctl(),            6'b000000);
        tick();
        rst = 1'b0;
        clr();
        step("post_rst");

        // randomized traffic over a small register window to provoke matches
        for (int i = 0; i < 600; i++) begin
            rst                = ($urandom_range(0, 63) == 0);
            bus.Rs_D           = 5'($urandom_range(0, 3));
            bus.Rt_D           = 5'($urandom_range(0, 3));
            bus.Uses_Rt_D      = 1'($urandom_range(0, 1));
            bus.Branch_D       = 1'($urandom_range(0, 1));
            bus.Branch_Taken_D = 1'($urandom_range(0, 1));
            bus.Mem_Read_E     = 1'($urandom_range(0, 1));
            bus.Reg_Write_E    = 1'($urandom_range(0, 1));
            bus.Write_Reg_E    = 5'($urandom_range(0, 3));
            bus.Mem_To_Reg_M   = 1'($urandom_range(0, 1));
            bus.Write_Reg_M    = 5'($urandom_range(0, 3));
            bus.Mem_Access_M   = 1'($urandom_range(0, 1));
            bus.Mem_Ready      = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
